// File: rtl/softex_stream_slicer.sv
// Serializes wide strobed load beats into narrow datapath slices, skipping
// all-zero-strobe slices, and tracks beat count against a programmed job length.
module softex_stream_slicer #(
  parameter int IN_DW  = 128,
  parameter int OUT_DW = 32,
  parameter int LEN_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [IN_DW-1:0]      in_data_i,
  input  logic [IN_DW/8-1:0]    in_strb_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [OUT_DW-1:0]     out_data_o,
  output logic [OUT_DW/8-1:0]   out_strb_o,
  output logic                  out_last_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int NSLICE = IN_DW / OUT_DW;
  localparam int SB     = OUT_DW / 8;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    beats_reg;
  logic [IN_DW-1:0]    data_reg;
  logic [IN_DW/8-1:0]  strb_reg;
  logic [NSLICE-1:0]   mask_reg;
  logic                final_reg;

  logic [NSLICE-1:0]   in_mask;
  logic [NSLICE-1:0]   mask_rest;
  logic [IDX_W-1:0]    cur_idx;
  logic [OUT_DW-1:0]   data_slices [NSLICE];
  logic [SB-1:0]       strb_slices [NSLICE];
  logic                hold_valid;
  logic                out_hs;
  logic                last_slice_hs;
  logic                in_hs;
  logic                last_beat;
  logic                job_end;

  genvar gi;
  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_slice
      assign in_mask[gi]     = |in_strb_i[gi*SB +: SB];
      assign data_slices[gi] = data_reg[gi*OUT_DW +: OUT_DW];
      assign strb_slices[gi] = strb_reg[gi*SB +: SB];
    end
  endgenerate

  // Lowest set mask bit is the current slice; clearing it leaves the rest.
  assign mask_rest = mask_reg & (mask_reg - NSLICE'(1));

  always_comb begin
    cur_idx = '0;
    for (int k = NSLICE - 1; k >= 0; k--) begin
      if (mask_reg[k]) cur_idx = IDX_W'(k);
    end
  end

  assign hold_valid    = |mask_reg;
  assign out_hs        = hold_valid && out_ready_i;
  assign last_slice_hs = out_hs && (mask_rest == '0);
  assign in_ready_o    = (state_reg == RUN) && (beats_reg != '0) &&
                         (!hold_valid || last_slice_hs);
  assign in_hs         = in_valid_i && in_ready_o;
  assign last_beat     = (beats_reg == LEN_W'(1));
  // A final beat with an empty strobe is consumed without ever being held.
  assign job_end       = (last_slice_hs && final_reg) ||
                         (in_hs && last_beat && (in_mask == '0));

  assign out_valid_o = hold_valid;
  assign out_data_o  = hold_valid ? data_slices[cur_idx] : '0;
  assign out_strb_o  = hold_valid ? strb_slices[cur_idx] : '0;
  assign out_last_o  = hold_valid && final_reg && (mask_rest == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else if (clear_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = (len_i != '0) ? RUN : DONE;
      RUN:     if (job_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_reg == RUN);
    done_o = (state_reg == DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beats_reg <= '0;
      data_reg  <= '0;
      strb_reg  <= '0;
      mask_reg  <= '0;
      final_reg <= 1'b0;
    end else if (clear_i) begin
      beats_reg <= '0;
      data_reg  <= '0;
      strb_reg  <= '0;
      mask_reg  <= '0;
      final_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && start_i) begin
        beats_reg <= len_i;
      end else if (in_hs) begin
        beats_reg <= beats_reg - LEN_W'(1);
      end
      if (in_hs) begin
        data_reg  <= in_data_i;
        strb_reg  <= in_strb_i;
        mask_reg  <= in_mask;
        final_reg <= last_beat;
      end else if (out_hs) begin
        mask_reg  <= mask_rest;
      end
    end
  end

endmodule

// File: tb/tb_softex_stream_slicer.sv
// Table-driven bench for softex_stream_slicer with a slice scoreboard and a
// small job-state model; abort and idle cases are hand-written sequences.
module tb_softex_stream_slicer;

  localparam int IN_DW  = 128;
  localparam int OUT_DW = 32;
  localparam int LEN_W  = 16;
  localparam int NS     = IN_DW / OUT_DW;
  localparam int SB     = OUT_DW / 8;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 clear_i;
  logic                 start_i;
  logic [LEN_W-1:0]     len_i;
  logic [IN_DW-1:0]     in_data_i;
  logic [IN_DW/8-1:0]   in_strb_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [OUT_DW-1:0]    out_data_o;
  logic [SB-1:0]        out_strb_o;
  logic                 out_last_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 busy_o;
  logic                 done_o;

  softex_stream_slicer #(.IN_DW(IN_DW), .OUT_DW(OUT_DW), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
    .in_data_i(in_data_i), .in_strb_i(in_strb_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_strb_o(out_strb_o),
    .out_last_o(out_last_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [OUT_DW-1:0] data;
    logic [SB-1:0]     strb;
    logic              last;
  } slice_t;

  typedef struct {
    int            len;
    logic [127:0]  d0;
    logic [15:0]   s0;
    logic [127:0]  d1;
    logic [15:0]   s1;
    int            ready_mode;  // 0 always, 1 toggle, 2 random
    bit            start_mid;
    int            exp_hs;
    int            exp_span;    // -1 = not checked
  } vec_t;

  slice_t q[$];
  int checks = 0;
  int errors = 0;
  int mst = 0;          // 0 idle, 1 run, 2 done
  int beats_left = 0;
  int hs_cnt, first_hs, last_hs;
  int cyc = 0;
  bit last_in_hs;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mst = 0;
    beats_left = 0;
  endtask

  // Check one cycle (inputs already driven), advance the model, move to next negedge.
  task automatic step();
    slice_t s;
    bit out_hs, in_hs, done_c, fin, exp_rdy;
    int hi;
    #1;
    exp_rdy = (mst == 1) && (beats_left != 0) &&
              (q.size() == 0 || (q.size() == 1 && out_ready_i));
    chk("busy", busy_o, (mst == 1));
    chk("done", done_o, (mst == 2));
    chk("out_valid", out_valid_o, (q.size() != 0));
    chk("in_ready", in_ready_o, exp_rdy);
    if (q.size() != 0 && out_valid_o) begin
      chk("out_data", out_data_o, q[0].data);
      chk("out_strb", out_strb_o, q[0].strb);
      chk("out_last", out_last_o, q[0].last);
    end
    out_hs = out_valid_o && out_ready_i;
    in_hs  = in_valid_i && in_ready_o;
    last_in_hs = in_hs;
    done_c = 1'b0;
    if (clear_i) begin
      model_reset();
    end else begin
      if (out_hs && q.size() != 0) begin
        s = q.pop_front();
        hs_cnt++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (s.last) done_c = 1'b1;
      end
      if (in_hs && mst == 1 && beats_left > 0) begin
        beats_left--;
        fin = (beats_left == 0);
        hi = -1;
        for (int k = 0; k < NS; k++) if (|in_strb_i[k*SB +: SB]) hi = k;
        for (int k = 0; k < NS; k++) begin
          if (|in_strb_i[k*SB +: SB]) begin
            s.data = in_data_i[k*OUT_DW +: OUT_DW];
            s.strb = in_strb_i[k*SB +: SB];
            s.last = fin && (k == hi);
            q.push_back(s);
          end
        end
        if (fin && hi < 0) done_c = 1'b1;
      end
      case (mst)
        0: if (start_i) begin
             if (len_i != 0) begin mst = 1; beats_left = int'(len_i); end
             else mst = 2;
           end
        1: if (done_c) mst = 2;
        default: mst = 0;
      endcase
    end
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run_job(input vec_t v);
    int presented, t;
    presented = 0;
    t = 0;
    hs_cnt = 0; first_hs = -1; last_hs = -1;
    start_i = 1'b1; len_i = LEN_W'(v.len); in_valid_i = 1'b0; out_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    while (mst != 0 && t < 300) begin
      in_valid_i  = (presented < v.len);
      in_data_i   = (presented == 0) ? v.d0 : v.d1;
      in_strb_i   = (presented == 0) ? v.s0 : v.s1;
      out_ready_i = (v.ready_mode == 0) ? 1'b1 :
                    (v.ready_mode == 1) ? ((t % 2) == 0) : 1'($urandom_range(0, 1));
      start_i     = v.start_mid && (t == 2);
      len_i       = start_i ? LEN_W'(5) : LEN_W'(v.len);
      step();
      if (last_in_hs) presented++;
      t++;
    end
    start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    if (t >= 300) begin
      checks++; errors++;
      $display("FAIL job_timeout: got still busy expected idle within 300 cycles");
    end
    chk("hs_count", hs_cnt, v.exp_hs);
    if (v.exp_span >= 0) chk("slice_span", last_hs - first_hs, v.exp_span);
    $display("job len=%0d mode=%0d: %0d slices, checks=%0d errors=%0d",
             v.len, v.ready_mode, hs_cnt, checks, errors);
  endtask

  task automatic abort_test(input bit use_rst, input logic [127:0] d);
    int t;
    vec_t nv;
    hs_cnt = 0; first_hs = -1; last_hs = -1; t = 0;
    start_i = 1'b1; len_i = LEN_W'(1); out_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    while (hs_cnt < 2 && t < 50) begin
      in_valid_i = (mst == 1) && (beats_left != 0);
      in_data_i = d; in_strb_i = '1;
      step();
      t++;
    end
    in_valid_i = 1'b0;
    chk("abort_reached_slice2", hs_cnt, 2);
    if (use_rst) begin
      rst_i = 1'b1;
      #1;
      chk("rst_out_valid", out_valid_o, 1'b0);
      chk("rst_out_data", out_data_o, 0);
      chk("rst_out_strb", out_strb_o, 0);
      chk("rst_out_last", out_last_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_in_ready", in_ready_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
    end else begin
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      chk("clr_out_data", out_data_o, 0);
    end
    step();
    step();
    $display("abort via %s: checks=%0d errors=%0d", use_rst ? "rst" : "clear", checks, errors);
    nv = '{len: 1, d0: d, s0: 16'hFFFF, d1: '0, s1: '0,
           ready_mode: 0, start_mid: 0, exp_hs: 4, exp_span: 3};
    run_job(nv);
  endtask

  vec_t vecs [9];

  initial begin
    logic [127:0] d_a, d_b, d_c;
    d_a = 128'h33332222_11110000_DDDDCCCC_BBBBAAAA;
    d_b = 128'h00000000_00000000_77776666_55554444;
    d_c = 128'h44444444_33333333_22222222_11111111;
    vecs[0] = '{2, d_a, 16'hFFFF, d_b, 16'hFFFF, 0, 0, 8, 7};
    vecs[1] = '{1, d_c, 16'hF0F0, '0,  16'h0000, 0, 0, 2, 1};
    vecs[2] = '{2, d_a, 16'hFFFF, d_b, 16'hFFFF, 1, 0, 8, -1};
    vecs[3] = '{0, '0,  16'h0000, '0,  16'h0000, 0, 0, 0, -1};
    vecs[4] = '{1, d_c, 16'h0000, '0,  16'h0000, 0, 0, 0, -1};
    vecs[5] = '{2, d_c, 16'hFFFF, d_a, 16'h0000, 0, 0, 4, -1};
    vecs[6] = '{2, d_c, 16'h0F00, d_a, 16'h000F, 2, 0, 2, -1};
    vecs[7] = '{1, d_a, 16'h1248, '0,  16'h0000, 2, 0, 4, -1};
    vecs[8] = '{1, d_c, 16'hFFFF, '0,  16'h0000, 0, 1, 4, 3};

    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0;
    in_data_i = '0; in_strb_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("reset_out_valid", out_valid_o, 1'b0);
    chk("reset_in_ready", in_ready_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    chk("reset_out_data", out_data_o, 0);
    rst_i = 1'b0;

    // Beats offered while idle must not be accepted.
    in_valid_i = 1'b1; in_data_i = d_a; in_strb_i = '1;
    for (int i = 0; i < 3; i++) step();
    in_valid_i = 1'b0;

    for (int i = 0; i < 9; i++) run_job(vecs[i]);

    abort_test(1'b1, d_a);
    abort_test(1'b0, d_c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/softex_stream_slicer.md
Name: softex_stream_slicer

Overview:
- Sits directly downstream of the SoftEx streamer load channel and upstream of the datapath lanes.
- Accepts wide, strobed load beats and serializes each one into NSLICE narrow slices for the datapath.
- Drops slices whose strobe is all-zero, with no bubble cycles.
- Counts beats against a programmed job length, marks the final slice and signals job completion.

Parameters:
IN_DW, 128, input stream data width in bits; must be an integer multiple of OUT_DW.
OUT_DW, 32, output slice width in bits; must be a multiple of 8.
LEN_W, 16, width of the beat-length field.

Ports:
clk_i  in  1  clock.
rst_i  in  1  asynchronous reset, active-high.
clear_i  in  1  synchronous clear; same effect as reset.
start_i  in  1  one-cycle pulse that starts a job; ignored unless in IDLE.
len_i  in  LEN_W  number of input beats in the job; sampled on start_i.
in_data_i  in  IN_DW  input beat data.
in_strb_i  in  IN_DW/8  input byte strobes.
in_valid_i  in  1  input valid.
in_ready_o  out  1  input ready.
out_data_o  out  OUT_DW  slice data.
out_strb_o  out  OUT_DW/8  slice byte strobes.
out_last_o  out  1  final emitted slice of the job.
out_valid_o  out  1  slice valid.
out_ready_i  in  1  slice ready.
busy_o  out  1  high in RUN.
done_o  out  1  one-cycle completion pulse.

Behaviour:
- Derived constant: NSLICE = IN_DW/OUT_DW. Slice k is data bits [k*OUT_DW +: OUT_DW] with the matching strobe sub-field; slices are emitted in ascending k.
- Reset and clear values:
  - FSM = IDLE; holding register empty; beat counter 0.
  - All outputs 0, including in_ready_o, out_valid_o, busy_o and done_o.
  - An asynchronous reset mid-job aborts the job immediately, with no done_o.
  - clear_i aborts on the next edge and has priority over every other event in that cycle.
- FSM states:
  - IDLE -> RUN on start_i with len_i != 0. The remaining-beat count is loaded with len_i.
  - IDLE -> DONE on start_i with len_i == 0.
  - RUN -> DONE when the last beat has been consumed: either its final non-empty slice handshakes, or it was accepted with an all-zero strobe.
  - DONE -> IDLE unconditionally after one cycle. done_o = 1 only in DONE.
- Holding register: one beat of data, strobe and a remaining-slice mask. The mask bit for slice k is set iff slice k's strobe is nonzero.
  - The current slice is the lowest set mask bit, found by a combinational priority encoder, so empty slices cost zero cycles.
- Input handshake:
  - in_ready_o = (state==RUN) && (remaining beats > 0) && (holding empty, or its last set mask bit is handshaking this cycle).
  - This gives back-to-back beats with no bubble.
  - A beat accepted with an all-zero strobe is consumed without being held: the beat counter decrements and no slice is emitted.
- Output:
  - out_valid_o = holding register non-empty. Outputs are driven from the register, so the first slice appears the cycle after beat acceptance.
  - out_data_o, out_strb_o and out_last_o must stay stable while out_valid_o=1 and out_ready_i=0.
  - On handshake the current mask bit is cleared. When the mask becomes empty the register empties, unless a new beat loads in the same cycle.
- out_last_o = 1 on the highest non-empty slice of the final beat only. If the final beat has an all-zero strobe, no slice carries out_last_o; done_o still pulses.
- Throughput: one slice per cycle at out_ready_i=1. A full-strobe beat takes NSLICE cycles.
- Beats presented while not in RUN, or after len_i beats have been accepted, are not accepted (in_ready_o=0).
- The beat counter is LEN_W bits wide and decrements once per accepted beat. It cannot wrap, because acceptance stops at 0.

Test Plan:
1. Full-strobe throughput: IN_DW=128, OUT_DW=32, len_i=2, beats 0x33332222_11110000_DDDDCCCC_BBBBAAAA and 0x0…0_77776666_55554444, all strobes 1, out_ready_i=1.
   -> Slices BBBBAAAA, DDDDCCCC, 11110000, 33332222, then 55554444, 77776666, 0, 0, on 8 consecutive cycles.
   -> out_last_o on the 8th slice; done_o one cycle after it; busy_o then 0.
2. Sparse strobe: in_strb_i=0xF0F0 (slices 1 and 3 only), len_i=1.
   -> Exactly 2 slices, on consecutive cycles.
   -> Second slice has out_strb_o=0xF and out_last_o=1.
3. Back-pressure: toggle out_ready_i 1/0 every cycle in scenario 1.
   -> Every slice is held stable while stalled; 8 handshakes total.
   -> in_ready_o never rises while a second beat is still pending in the register.
4. Zero-length and zero-strobe jobs:
   -> start_i with len_i=0: done_o 1 cycle later, no out_valid_o.
   -> len_i=1 with in_strb_i=0: beat accepted, no slice emitted, done_o pulses, no out_last_o.
5. Abort: assert rst_i asynchronously, then clear_i in a separate run, each after slice 2 of 4.
   -> Outputs 0 immediately (rst_i) or at the next edge (clear_i); no done_o; state IDLE.
   -> A following start_i with len_i=1 runs normally.
6. Ignored starts: start_i during RUN; in_valid_i=1 in IDLE.
   -> No state change; in_ready_o stays 0 in IDLE.
